// File: rtl/adc_nch_decim_if.sv
// Output stream bundle of adc_nch_decim: packed multi-channel word with valid/ready.
// Member names keep the original m_axis_* port names.
interface adc_nch_decim_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned OUT_W  = 16
) ();
   logic [NUM_CH*OUT_W-1:0] m_axis_tdata;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;

   modport master (output m_axis_tdata, output m_axis_tvalid, input m_axis_tready);
   modport slave  (input m_axis_tdata, input m_axis_tvalid, output m_axis_tready);
endinterface

// File: rtl/adc_nch_decim.sv
// NUM_CH-channel ADC capture, offset-binary conversion and 2**DEC_LOG2 boxcar averaging onto a valid/ready stream.
// Optional sticky per-channel full-scale flags (sat port) when ADC_SAT_DETECT_EN is defined.
module adc_nch_decim #(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned ADC_W    = 14,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned DEC_LOG2 = 0
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [NUM_CH*ADC_W-1:0] adc_data,
   input  logic                    en,
   input  logic                    fmt_offset_bin,
   adc_nch_decim_if.master         m_axis,
   output logic                    ovf,
   input  logic                    ovf_clr
`ifdef ADC_SAT_DETECT_EN
   ,
   output logic [NUM_CH-1:0]       sat
`endif
);

   localparam int unsigned AW    = ADC_W + DEC_LOG2;
   localparam int unsigned CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);

   logic [NUM_CH*ADC_W-1:0] s1_q;
   logic                    v1_q;
   logic                    v2_q;
   logic signed [ADC_W-1:0] x_d   [NUM_CH];
   logic signed [ADC_W-1:0] x_q   [NUM_CH];
   logic signed [AW-1:0]    sum_d [NUM_CH];
   logic signed [AW-1:0]    acc_q [NUM_CH];
   logic [CNT_W-1:0]        cnt_d, cnt_q;
   logic [NUM_CH*OUT_W-1:0] res_d, tdata_d, tdata_q;
   logic                    tvalid_d, tvalid_q;
   logic                    ovf_d, ovf_q;
   logic                    load, drop;

   // The first sample of a window replaces the accumulator, so abandoned windows leave no residue.
   always_comb begin
      res_d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         x_d[c] = s1_q[c*ADC_W +: ADC_W];
         if (fmt_offset_bin) begin
            x_d[c][ADC_W-1] = ~s1_q[c*ADC_W + ADC_W - 1];
         end
         sum_d[c] = (cnt_q == '0) ? AW'(x_q[c]) : acc_q[c] + AW'(x_q[c]);
         res_d[c*OUT_W +: OUT_W] = OUT_W'(sum_d[c] >>> DEC_LOG2);
      end
   end

   always_comb begin
      load     = v2_q && (cnt_q == CNT_LAST);
      drop     = load && tvalid_q && !m_axis.m_axis_tready;
      cnt_d    = '0;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      if (v2_q && !load) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (load && !drop) begin
         tdata_d  = res_d;
         tvalid_d = 1'b1;
      end else if (tvalid_q && m_axis.m_axis_tready) begin
         tvalid_d = 1'b0;
      end
      ovf_d = drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s1_q     <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            x_q[c]   <= '0;
            acc_q[c] <= '0;
         end
      end else begin
         s1_q     <= adc_data;
         v1_q     <= en;
         v2_q     <= v1_q;
         cnt_q    <= cnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         ovf_q    <= ovf_d;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            x_q[c] <= x_d[c];
            if (v2_q) begin
               acc_q[c] <= sum_d[c];
            end
         end
      end
   end

   assign m_axis.m_axis_tdata  = tdata_q;
   assign m_axis.m_axis_tvalid = tvalid_q;
   assign ovf                  = ovf_q;

`ifdef ADC_SAT_DETECT_EN
   localparam logic [ADC_W-1:0] CODE_MIN = {1'b1, {(ADC_W-1){1'b0}}};
   localparam logic [ADC_W-1:0] CODE_MAX = ~CODE_MIN;

   logic [NUM_CH-1:0] sat_d, sat_q, hit;

   // Full-scale is judged on the converted S2 value of valid samples only.
   always_comb begin
      hit = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         hit[c] = v1_q && (($unsigned(x_d[c]) == CODE_MIN) || ($unsigned(x_d[c]) == CODE_MAX));
      end
      sat_d = hit | (sat_q & ~{NUM_CH{ovf_clr}});
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sat_q <= '0;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign sat = sat_q;
`endif

endmodule

// File: tb/tb_adc_nch_decim.sv
// Directed bench for adc_nch_decim: pass-through instance (DEC_LOG2=0) and 4x averaging instance (DEC_LOG2=2).
module tb_adc_nch_decim;
   localparam int unsigned NCH = 2;
   localparam int unsigned AW  = 14;
   localparam int unsigned OW  = 16;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic              aresetn, en, fmt, ovf_clr;
   logic [NCH*AW-1:0] adc;
   logic              ovf0, ovf2;
`ifdef ADC_SAT_DETECT_EN
   logic [NCH-1:0]    sat0, sat2;
`endif

   adc_nch_decim_if #(.NUM_CH(NCH), .OUT_W(OW)) if0 ();
   adc_nch_decim_if #(.NUM_CH(NCH), .OUT_W(OW)) if2 ();

   adc_nch_decim #(.NUM_CH(NCH), .ADC_W(AW), .OUT_W(OW), .DEC_LOG2(0)) dut0 (
      .aclk(aclk), .aresetn(aresetn), .adc_data(adc), .en(en), .fmt_offset_bin(fmt),
      .m_axis(if0), .ovf(ovf0), .ovf_clr(ovf_clr)
`ifdef ADC_SAT_DETECT_EN
      , .sat(sat0)
`endif
   );

   adc_nch_decim #(.NUM_CH(NCH), .ADC_W(AW), .OUT_W(OW), .DEC_LOG2(2)) dut2 (
      .aclk(aclk), .aresetn(aresetn), .adc_data(adc), .en(en), .fmt_offset_bin(fmt),
      .m_axis(if2), .ovf(ovf2), .ovf_clr(ovf_clr)
`ifdef ADC_SAT_DETECT_EN
      , .sat(sat2)
`endif
   );

   typedef struct {
      logic          fmt;
      logic [AW-1:0] c0;
      logic [AW-1:0] c1;
      logic [31:0]   exp;
   } vec_t;

   vec_t tbl [6];
   int   n_vec;
   int   n_err;
   int   avg0 [8] = '{100, 101, 102, 104, 0, 0, 0, 3};
   int   avg1 [8] = '{-3, -3, -3, -2, -1, 0, 0, 0};
   int   part0 [4] = '{8, 8, 8, 12};

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [AW-1:0] c0, input logic [AW-1:0] c1);
      en  = e;
      adc = {c1, c0};
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      aresetn = 1'b0;
      en = 1'b0;
      fmt = 1'b0;
      ovf_clr = 1'b0;
      adc = '0;
      if0.m_axis_tready = 1'b1;
      if2.m_axis_tready = 1'b1;

      tbl[0] = '{1'b1, 14'h2000, 14'h3FFF, {16'h1FFF, 16'h0000}};
      tbl[1] = '{1'b1, 14'h0000, 14'h1FFF, {16'hFFFF, 16'hE000}};
      tbl[2] = '{1'b0, 14'h1FFF, 14'h2000, {16'hE000, 16'h1FFF}};
      tbl[3] = '{1'b0, 14'h0064, 14'h3FFD, {16'hFFFD, 16'h0064}};
      tbl[4] = '{1'b1, 14'h2001, 14'h1FFE, {16'hFFFE, 16'h0001}};
      tbl[5] = '{1'b0, 14'h3FFF, 14'h0000, {16'h0000, 16'hFFFF}};

      repeat (2) tick();
      chk("rst_tdata0", if0.m_axis_tdata, 32'h0);
      chk("rst_tvalid0", {31'b0, if0.m_axis_tvalid}, 32'h0);
      chk("rst_ovf0", {31'b0, ovf0}, 32'h0);
      chk("rst_tdata2", if2.m_axis_tdata, 32'h0);
      chk("rst_tvalid2", {31'b0, if2.m_axis_tvalid}, 32'h0);
      chk("rst_ovf2", {31'b0, ovf2}, 32'h0);
      #3 aresetn = 1'b1;

      // Pass-through conversion table: each vector held until it has crossed all three stages.
      for (int i = 0; i < 6; i++) begin
         fmt = tbl[i].fmt;
         drive(1'b1, tbl[i].c0, tbl[i].c1);
         repeat (3) tick();
         chk($sformatf("tbl%0d_tdata", i), if0.m_axis_tdata, tbl[i].exp);
         chk($sformatf("tbl%0d_tvalid", i), {31'b0, if0.m_axis_tvalid}, 32'h1);
      end

      en = 1'b0;
      fmt = 1'b0;
      repeat (4) tick();

      // Two back-to-back 4-sample windows, including floor rounding of negatives.
      for (int n = 1; n <= 11; n++) begin
         if (n <= 8) drive(1'b1, 14'(avg0[n-1]), 14'(avg1[n-1]));
         else en = 1'b0;
         tick();
         chk($sformatf("avg_tvalid_t%0d", n), {31'b0, if2.m_axis_tvalid}, {31'b0, (n == 6 || n == 10)});
         if (n == 6)  chk("avg_word0", if2.m_axis_tdata, {16'(-3), 16'(101)});
         if (n == 10) chk("avg_word1", if2.m_axis_tdata, {16'(-1), 16'(0)});
      end

      repeat (3) tick();

      // Backpressure: first word held, later loads dropped and flagged.
      if0.m_axis_tready = 1'b0;
      drive(1'b1, 14'h0011, 14'h0001); tick();
      drive(1'b1, 14'h0022, 14'h0002); tick();
      drive(1'b1, 14'h0033, 14'h0003); tick();
      chk("hold_tvalid", {31'b0, if0.m_axis_tvalid}, 32'h1);
      chk("hold_tdata", if0.m_axis_tdata, {16'h0001, 16'h0011});
      chk("hold_ovf_clear", {31'b0, ovf0}, 32'h0);
      en = 1'b0;
      tick();
      chk("ovf_set", {31'b0, ovf0}, 32'h1);
      chk("hold_tdata_after_drop", if0.m_axis_tdata, {16'h0001, 16'h0011});
      ovf_clr = 1'b1;
      tick();
      chk("ovf_set_wins", {31'b0, ovf0}, 32'h1);
      tick();
      chk("ovf_cleared", {31'b0, ovf0}, 32'h0);
      chk("hold_tvalid_late", {31'b0, if0.m_axis_tvalid}, 32'h1);
      chk("hold_tdata_late", if0.m_axis_tdata, {16'h0001, 16'h0011});
      ovf_clr = 1'b0;
      if0.m_axis_tready = 1'b1;
      tick();
      chk("xfer_tvalid_drop", {31'b0, if0.m_axis_tvalid}, 32'h0);
      tick();
      chk("xfer_once", {31'b0, if0.m_axis_tvalid}, 32'h0);

      repeat (3) tick();

      // Partial window abandoned when en drops; next window aligned to en rise.
      for (int n = 1; n <= 12; n++) begin
         if (n <= 2) drive(1'b1, 14'd1000, 14'd1000);
         else if (n <= 5) en = 1'b0;
         else if (n <= 9) drive(1'b1, 14'(part0[n-6]), 14'(-4));
         else en = 1'b0;
         tick();
         chk($sformatf("part_tvalid_t%0d", n), {31'b0, if2.m_axis_tvalid}, {31'b0, (n == 11)});
         if (n == 11) chk("part_word", if2.m_axis_tdata, {16'(-4), 16'(9)});
      end

      repeat (3) tick();

      // Asynchronous reset mid-window with words pending on both instances.
      if0.m_axis_tready = 1'b0;
      if2.m_axis_tready = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         drive(1'b1, 14'd40, 14'(-8));
         tick();
      end
      chk("pre_rst_tvalid0", {31'b0, if0.m_axis_tvalid}, 32'h1);
      chk("pre_rst_ovf0", {31'b0, ovf0}, 32'h1);
      chk("pre_rst_tvalid2", {31'b0, if2.m_axis_tvalid}, 32'h1);
      #3 aresetn = 1'b0;
      #1;
      chk("arst_tvalid0", {31'b0, if0.m_axis_tvalid}, 32'h0);
      chk("arst_tdata0", if0.m_axis_tdata, 32'h0);
      chk("arst_ovf0", {31'b0, ovf0}, 32'h0);
      chk("arst_tvalid2", {31'b0, if2.m_axis_tvalid}, 32'h0);
      chk("arst_tdata2", if2.m_axis_tdata, 32'h0);
      #1 aresetn = 1'b1;
      if0.m_axis_tready = 1'b1;
      if2.m_axis_tready = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         tick();
         chk($sformatf("post_rst_tvalid0_t%0d", n), {31'b0, if0.m_axis_tvalid}, {31'b0, (n >= 3)});
         chk($sformatf("post_rst_tvalid2_t%0d", n), {31'b0, if2.m_axis_tvalid}, {31'b0, (n == 6)});
         if (n == 6) chk("post_rst_word2", if2.m_axis_tdata, {16'(-8), 16'(40)});
      end
      en = 1'b0;
      repeat (3) tick();

`ifdef ADC_SAT_DETECT_EN
      fmt = 1'b1;
      drive(1'b1, 14'h1000, 14'h1000);
      repeat (2) tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("sat_cleared", {30'b0, sat0}, 32'h0);
      drive(1'b1, 14'h1000, 14'h3FFF);
      tick();
      chk("sat_not_yet", {30'b0, sat0}, 32'h0);
      tick();
      chk("sat_set", {30'b0, sat0}, 32'h2);
      drive(1'b1, 14'h1000, 14'h1000);
      repeat (3) tick();
      chk("sat_sticky", {30'b0, sat0}, 32'h2);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("sat_clr", {30'b0, sat0}, 32'h0);
      en = 1'b0;
      fmt = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
